// File: rtl/xip_arb_pkg.sv
// Shared definitions for the XIP read-port arbiter: controller state codes
// and the transfer size codes understood by the flash engine and the I-cache.
package xip_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_GAP  = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    typedef logic [1:0] xip_size_t;

    localparam xip_size_t SZ_BYTE = 2'd0;
    localparam xip_size_t SZ_HALF = 2'd1;
    localparam xip_size_t SZ_WORD = 2'd2;
    localparam xip_size_t SZ_LINE = 2'd3;

endpackage

// File: rtl/xip_rr2.sv
// Two-way request picker. With both requesting, round-robin mode favours the
// requester that was not granted last; fixed mode always favours requester 0.
module xip_rr2
    import xip_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_mode,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (rr_mode && !last) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/xip_arb.sv
// Arbiter/sequencer between the I-cache refill port (r0), the data-load port
// (r1) and the single read port of the serial-flash XIP engine.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transfer, m_valid low, grant on any request
// BUSY    | m_valid high, addr/size frozen, watchdog running
// RESP    | first m_valid-low cycle, response registered toward requester
// GAP     | remaining chip-select idle cycles, grant when the gap expires
module xip_arb
    import xip_arb_pkg::*;
#(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1023,
    parameter bit RR      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_valid,
    input  logic [31:0] r0_addr,
    input  logic [1:0]  r0_size,
    output logic        r0_ready,
    output logic        r0_err,
    output logic [31:0] r0_rdata,

    input  logic        r1_valid,
    input  logic [31:0] r1_addr,
    input  logic [1:0]  r1_size,
    output logic        r1_ready,
    output logic        r1_err,
    output logic [31:0] r1_rdata,

    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [1:0]  m_size,
    output logic        m_write,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP + 1);

    // Both timers count down; the load values make the terminal count land on
    // the TIMEOUT-th BUSY cycle and on the GAP-th m_valid-low cycle.
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              any_req;
    logic              last_gnt;
    logic              gnt_idx;
    logic [WD_W-1:0]   wd_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              gap_end;
    logic              wd_end;
    logic [31:0]       cap_data;
    logic              cap_err;
    logic              do_grant;
    logic              do_done;
    logic              do_expire;
    logic              do_resp;

    assign req     = {r1_valid, r0_valid};
    assign any_req = |req;
    assign gap_end = (gap_cnt == '0);
    assign wd_end  = (wd_cnt == '0);

    assign m_write = 1'b0;
    assign m_wdata = 32'h0;

    xip_rr2 u_rr2 (
        .req     (req),
        .last    (last_gnt),
        .rr_mode (RR),
        .gnt     (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_req) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (m_ready || wd_end) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (!gap_end)     state_nxt = ST_GAP;
                else if (any_req) state_nxt = ST_BUSY;
                else              state_nxt = ST_IDLE;
            end
            ST_GAP: begin
                if (gap_end) state_nxt = any_req ? ST_BUSY : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // m_valid decodes straight from the state register, so an asynchronous
    // reset drops it in the same cycle.
    always_comb begin
        m_valid   = (state == ST_BUSY);
        do_grant  = any_req && ((state == ST_IDLE) ||
                                (((state == ST_RESP) || (state == ST_GAP)) && gap_end));
        do_done   = (state == ST_BUSY) && m_ready;
        do_expire = (state == ST_BUSY) && !m_ready && wd_end;
        do_resp   = (state == ST_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr   <= 32'h0;
            m_size   <= 2'b00;
            gnt_idx  <= 1'b0;
            last_gnt <= 1'b1;
        end else if (do_grant) begin
            m_addr   <= (r0_addr & {32{gnt[0]}}) | (r1_addr & {32{gnt[1]}});
            m_size   <= (r0_size & {2{gnt[0]}})  | (r1_size & {2{gnt[1]}});
            gnt_idx  <= gnt[1];
            last_gnt <= gnt[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (do_grant) begin
            wd_cnt <= WD_LOAD;
        end else if ((state == ST_BUSY) && !wd_end) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_data <= 32'h0;
            cap_err  <= 1'b0;
            gap_cnt  <= '0;
        end else if (do_done) begin
            cap_data <= m_rdata;
            cap_err  <= 1'b0;
            gap_cnt  <= GAP_LOAD;
        end else if (do_expire) begin
            cap_data <= 32'h0;
            cap_err  <= 1'b1;
            gap_cnt  <= GAP_LOAD;
        end else if (((state == ST_RESP) || (state == ST_GAP)) && !gap_end) begin
            gap_cnt  <= gap_cnt - 1'b1;
        end
    end

    // Responses are registered out of RESP, so the requester sees ready two
    // cycles after the engine's ready; rdata/err hold until that port's next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_ready <= 1'b0;
            r0_err   <= 1'b0;
            r0_rdata <= 32'h0;
            r1_ready <= 1'b0;
            r1_err   <= 1'b0;
            r1_rdata <= 32'h0;
        end else begin
            r0_ready <= do_resp && !gnt_idx;
            r1_ready <= do_resp && gnt_idx;
            if (do_resp && !gnt_idx) begin
                r0_rdata <= cap_data;
                r0_err   <= cap_err;
            end
            if (do_resp && gnt_idx) begin
                r1_rdata <= cap_data;
                r1_err   <= cap_err;
            end
        end
    end

endmodule

// File: tb/tb_xip_arb.sv
// Self-checking bench for xip_arb: two instances (round-robin GAP=2 TIMEOUT=63,
// fixed-priority GAP=3 TIMEOUT=15), a directed vector table, a reset case and random traffic.
module tb_xip_arb;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        rv   [2][2];
    logic [31:0] ra   [2][2];
    logic [1:0]  rs   [2][2];
    logic        rrdy [2][2];
    logic        rerr [2][2];
    logic [31:0] rrd  [2][2];
    logic        mv   [2];
    logic [31:0] ma   [2];
    logic [1:0]  msz  [2];
    logic        mw   [2];
    logic [31:0] mwd  [2];
    logic        mrdy [2];
    logic [31:0] mrd  [2];

    int n_chk  = 0;
    int n_fail = 0;

    int to_p  [2] = '{63, 15};
    int gap_p [2] = '{2, 3};
    int last_m[2];
    logic [31:0] rd_m [2][2];

    xip_arb #(.GAP(2), .TIMEOUT(63), .RR(1'b1)) dut0 (
        .clk(clk), .rst(rst),
        .r0_valid(rv[0][0]), .r0_addr(ra[0][0]), .r0_size(rs[0][0]),
        .r0_ready(rrdy[0][0]), .r0_err(rerr[0][0]), .r0_rdata(rrd[0][0]),
        .r1_valid(rv[0][1]), .r1_addr(ra[0][1]), .r1_size(rs[0][1]),
        .r1_ready(rrdy[0][1]), .r1_err(rerr[0][1]), .r1_rdata(rrd[0][1]),
        .m_valid(mv[0]), .m_addr(ma[0]), .m_size(msz[0]), .m_write(mw[0]),
        .m_wdata(mwd[0]), .m_ready(mrdy[0]), .m_rdata(mrd[0])
    );

    xip_arb #(.GAP(3), .TIMEOUT(15), .RR(1'b0)) dut1 (
        .clk(clk), .rst(rst),
        .r0_valid(rv[1][0]), .r0_addr(ra[1][0]), .r0_size(rs[1][0]),
        .r0_ready(rrdy[1][0]), .r0_err(rerr[1][0]), .r0_rdata(rrd[1][0]),
        .r1_valid(rv[1][1]), .r1_addr(ra[1][1]), .r1_size(rs[1][1]),
        .r1_ready(rrdy[1][1]), .r1_err(rerr[1][1]), .r1_rdata(rrd[1][1]),
        .m_valid(mv[1]), .m_addr(ma[1]), .m_size(msz[1]), .m_write(mw[1]),
        .m_wdata(mwd[1]), .m_ready(mrdy[1]), .m_rdata(mrd[1])
    );

    typedef struct {
        int          k;
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  s0;
        logic [1:0]  s1;
        int          lat;
        logic [31:0] data;
        int          ew;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_m[k] = 1;
            rd_m[k][0] = 32'h0;
            rd_m[k][1] = 32'h0;
        end
    endtask

    task automatic chk_reset_state(input int k);
        chk("rst m_valid", 32'(mv[k]), 32'd0);
        chk("rst m_addr", ma[k], 32'd0);
        chk("rst m_size", 32'(msz[k]), 32'd0);
        chk("rst m_write", 32'(mw[k]), 32'd0);
        chk("rst m_wdata", mwd[k], 32'd0);
        chk("rst ready", 32'({rrdy[k][1], rrdy[k][0]}), 32'd0);
        chk("rst err", 32'({rerr[k][1], rerr[k][0]}), 32'd0);
        chk("rst rdata0", rrd[k][0], 32'd0);
        chk("rst rdata1", rrd[k][1], 32'd0);
    endtask

    // Called at a negedge with the requests already driven; the following
    // posedge must be a grant point. Returns at the negedge of the last
    // m_valid-low cycle, i.e. just before the next grant point.
    task automatic xfer(input int k, input int lat, input logic [31:0] data, input int ew);
        int          ol;
        int          n;
        logic        ee;
        logic [31:0] ea;
        logic [31:0] er;
        logic [1:0]  es;
        ol = 1 - ew;
        ea = ra[k][ew];
        es = rs[k][ew];
        ee = (lat > to_p[k]);
        er = ee ? 32'h0 : data;
        n  = ee ? to_p[k] : lat;
        @(negedge clk);
        for (int i = 1; i <= n; i++) begin
            chk("m_valid busy", 32'(mv[k]), 32'd1);
            chk("m_addr", ma[k], ea);
            chk("m_size", 32'(msz[k]), 32'(es));
            chk("ready in busy", 32'({rrdy[k][1], rrdy[k][0]}), 32'd0);
            if (i == lat) begin
                mrdy[k] = 1'b1;
                mrd[k]  = data;
            end
            @(negedge clk);
            mrdy[k] = 1'b0;
            mrd[k]  = $urandom;
        end
        chk("m_valid resp", 32'(mv[k]), 32'd0);
        chk("ready early", 32'({rrdy[k][1], rrdy[k][0]}), 32'd0);
        @(negedge clk);
        chk("m_valid gap", 32'(mv[k]), 32'd0);
        chk("ready winner", 32'(rrdy[k][ew]), 32'd1);
        chk("ready other", 32'(rrdy[k][ol]), 32'd0);
        chk("rdata", rrd[k][ew], er);
        chk("err", 32'(rerr[k][ew]), 32'(ee));
        chk("rdata other hold", rrd[k][ol], rd_m[k][ol]);
        rd_m[k][ew] = er;
        rv[k][ew]   = 1'b0;
        for (int g = 2; g < gap_p[k]; g++) begin
            @(negedge clk);
            chk("m_valid gap", 32'(mv[k]), 32'd0);
            chk("ready one-shot", 32'({rrdy[k][1], rrdy[k][0]}), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int          ew;
        int          lat;
        int          r;
        int          j;
        logic [1:0]  pend;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mrdy[k] = 1'b0;
            mrd[k]  = 32'h0;
            for (int q = 0; q < 2; q++) begin
                rv[k][q] = 1'b0;
                ra[k][q] = 32'h0;
                rs[k][q] = 2'b00;
            end
        end
        model_reset();

        tbl[0]  = '{0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         2'd2, 2'd0, 40,  32'hDEAD_BEEF, 0};
        tbl[1]  = '{0, 1'b0, 1'b1, 32'h0,         32'h0000_2000, 2'd0, 2'd1, 3,   32'h1111_1111, 1};
        tbl[2]  = '{0, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_4000, 2'd2, 2'd3, 5,   32'hA000_0000, 0};
        tbl[3]  = '{0, 1'b1, 1'b1, 32'h0000_3004, 32'h0000_4000, 2'd2, 2'd3, 7,   32'hA000_0001, 1};
        tbl[4]  = '{0, 1'b1, 1'b1, 32'h0000_3004, 32'h0000_4004, 2'd1, 2'd3, 1,   32'hA000_0002, 0};
        tbl[5]  = '{0, 1'b1, 1'b1, 32'h0000_3008, 32'h0000_4004, 2'd1, 2'd3, 2,   32'hA000_0003, 1};
        tbl[6]  = '{1, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_6000, 2'd2, 2'd1, 4,   32'hB000_0000, 0};
        tbl[7]  = '{1, 1'b1, 1'b1, 32'h0000_5004, 32'h0000_6000, 2'd2, 2'd1, 4,   32'hB000_0001, 0};
        tbl[8]  = '{1, 1'b1, 1'b1, 32'h0000_5008, 32'h0000_6000, 2'd2, 2'd1, 4,   32'hB000_0002, 0};
        tbl[9]  = '{1, 1'b0, 1'b1, 32'h0,         32'h0000_6000, 2'd0, 2'd1, 4,   32'hB000_0003, 1};
        tbl[10] = '{1, 1'b0, 1'b1, 32'h0,         32'h0000_7000, 2'd0, 2'd2, 100, 32'hC000_0000, 1};
        tbl[11] = '{1, 1'b1, 1'b0, 32'h0000_8000, 32'h0,         2'd3, 2'd0, 6,   32'hC000_0001, 0};
        tbl[12] = '{1, 1'b1, 1'b0, 32'h0000_8100, 32'h0,         2'd0, 2'd0, 15,  32'hC000_0002, 0};
        tbl[13] = '{1, 1'b0, 1'b1, 32'h0,         32'h0000_9000, 2'd0, 2'd2, 16,  32'hC000_0003, 1};
        tbl[14] = '{0, 1'b0, 1'b1, 32'h0,         32'h0000_A000, 2'd0, 2'd2, 63,  32'hD000_0000, 1};
        tbl[15] = '{0, 1'b1, 1'b0, 32'h0000_A100, 32'h0,         2'd1, 2'd0, 64,  32'hD000_0001, 0};

        repeat (3) @(negedge clk);
        chk_reset_state(0);
        chk_reset_state(1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle m_valid0", 32'(mv[0]), 32'd0);
        chk("idle m_valid1", 32'(mv[1]), 32'd0);

        foreach (tbl[i]) begin
            rv[1 - tbl[i].k][0] = 1'b0;
            rv[1 - tbl[i].k][1] = 1'b0;
            rv[tbl[i].k][0] = tbl[i].v0;
            rv[tbl[i].k][1] = tbl[i].v1;
            ra[tbl[i].k][0] = tbl[i].a0;
            ra[tbl[i].k][1] = tbl[i].a1;
            rs[tbl[i].k][0] = tbl[i].s0;
            rs[tbl[i].k][1] = tbl[i].s1;
            xfer(tbl[i].k, tbl[i].lat, tbl[i].data, tbl[i].ew);
            last_m[tbl[i].k] = tbl[i].ew;
        end
        rv[0][0] = 1'b0; rv[0][1] = 1'b0;
        rv[1][0] = 1'b0; rv[1][1] = 1'b0;

        // Reset in the middle of a BUSY transfer.
        @(negedge clk);
        rv[0][0] = 1'b1;
        ra[0][0] = 32'h0000_B000;
        rs[0][0] = 2'd2;
        @(negedge clk);
        chk("pre-reset m_valid", 32'(mv[0]), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async reset m_valid", 32'(mv[0]), 32'd0);
        rv[0][0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_reset_state(0);
        repeat (6) begin
            @(negedge clk);
            chk("no response after reset", 32'({rrdy[0][1], rrdy[0][0]}), 32'd0);
            chk("m_valid after reset", 32'(mv[0]), 32'd0);
        end
        rv[0][0] = 1'b1;
        ra[0][0] = 32'h0000_C000;
        rs[0][0] = 2'd3;
        xfer(0, 7, 32'h1234_5678, 0);
        last_m[0] = 0;

        // Random traffic against the arbitration/timing model on the RR instance.
        pend = 2'b00;
        for (int t = 0; t < 40; t++) begin
            for (int q = 0; q < 2; q++) begin
                if (!pend[q] && ($urandom_range(0, 1) == 1)) begin
                    pend[q]  = 1'b1;
                    ra[0][q] = $urandom;
                    rs[0][q] = 2'($urandom_range(0, 3));
                end
            end
            if (pend == 2'b00) begin
                rv[0][0] = 1'b0;
                rv[0][1] = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    chk("rand idle m_valid", 32'(mv[0]), 32'd0);
                end
                j = $urandom_range(0, 1);
                pend[j]  = 1'b1;
                ra[0][j] = $urandom;
                rs[0][j] = 2'($urandom_range(0, 3));
            end
            rv[0][0] = pend[0];
            rv[0][1] = pend[1];
            if (pend == 2'b11) ew = 1 - last_m[0];
            else               ew = pend[1] ? 1 : 0;
            last_m[0] = ew;
            r = $urandom_range(0, 9);
            if (r == 0)      lat = 63;
            else if (r == 1) lat = 64;
            else             lat = $urandom_range(1, 70);
            xfer(0, lat, $urandom, ew);
            pend[ew] = 1'b0;
        end
        rv[0][0] = 1'b0;
        rv[0][1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("final idle m_valid", 32'(mv[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
